// File: rtl/sem_multi_ctrl.sv
// rtl/sem_multi_ctrl.sv - multi-channel level-crossing semaphore controller
// Shared register port and profile RAM; one timing FSM per channel.
module sem_multi_ctrl #(
  parameter int N_CH       = 2,
  parameter int PROF_DEPTH = 4,
  parameter int DUR_W      = 8,
  parameter int TICK_DIV   = 1000
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          ctl_wr,
  input  logic                          ctl_rd,
  input  logic [1:0]                    ctl_addr,
  input  logic [31:0]                   ctl_wrdata,
  output logic [31:0]                   ctl_rddata,
  input  logic                          ram_wr,
  input  logic [$clog2(PROF_DEPTH)-1:0] ram_addr,
  input  logic [4*DUR_W-1:0]            ram_wrdata,
  input  logic [N_CH-1:0]               train,
  output logic [N_CH-1:0]               red,
  output logic [N_CH-1:0]               yellow,
  output logic [N_CH-1:0]               green
);

  localparam int PW    = $clog2(PROF_DEPTH);
  localparam int WW    = 4 * DUR_W;
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int BLK_W = $clog2(2 * TICK_DIV);

  typedef enum logic [2:0] {
    S_DIS, S_RED_CLR, S_GMIN, S_GREEN, S_YELLOW, S_RED_OCC
  } st_t;

  logic                 enable;
  logic                 blink;
  logic [N_CH*PW-1:0]   psel;
  logic [31:0]          cnt;
  logic [N_CH-1:0]      fault;
  logic [WW-1:0]        prof_ram [PROF_DEPTH];

  st_t                  state [N_CH];
  st_t                  nxt   [N_CH];
  logic [WW-1:0]        prof  [N_CH];
  logic [PRE_W-1:0]     pre   [N_CH];
  logic [DUR_W-1:0]     tck   [N_CH];
  logic [BLK_W-1:0]     bcnt  [N_CH];
  logic [DUR_W-1:0]     dur   [N_CH];
  logic [DUR_W-1:0]     tlim  [N_CH];
  logic [DUR_W:0]       tck_inc [N_CH];
  logic [DUR_W:0]       dmax  [N_CH];
  logic [N_CH-1:0]      pend;
  logic [N_CH-1:0]      tick, done, tmo, served, entry, latch;
  logic [31:0]          inc;
  logic [31:0]          status;
  logic [31:0]          rd_mux;
  logic                 unused;

  assign unused = &{1'b0, ctl_wrdata};

  // Profile RAM has no reset; a write is seen by the asynchronous read next cycle.
  always_ff @(posedge clk) begin
    if (ram_wr) prof_ram[ram_addr] <= ram_wrdata;
  end

  always_comb begin
    inc = '0;
    for (int c = 0; c < N_CH; c++) begin
      tick[c]    = (pre[c] == PRE_W'(TICK_DIV - 1));
      tlim[c]    = prof[c][4*DUR_W-1:3*DUR_W];
      tck_inc[c] = {1'b0, tck[c]} + (DUR_W+1)'(1);
      case (state[c])
        S_RED_CLR: dur[c] = prof[c][3*DUR_W-1:2*DUR_W];
        S_GMIN:    dur[c] = prof[c][DUR_W-1:0];
        S_YELLOW:  dur[c] = prof[c][2*DUR_W-1:DUR_W];
        default:   dur[c] = tlim[c];
      endcase
      dmax[c] = (dur[c] == '0) ? (DUR_W+1)'(1) : {1'b0, dur[c]};
      done[c] = tick[c] && (tck_inc[c] >= dmax[c]);

      nxt[c] = state[c];
      if (!enable) begin
        nxt[c] = S_DIS;
      end else begin
        case (state[c])
          S_DIS:     nxt[c] = S_RED_CLR;
          S_RED_CLR: if (train[c]) nxt[c] = S_RED_OCC;
                     else if (done[c]) nxt[c] = S_GMIN;
          S_GMIN:    if (done[c]) nxt[c] = (pend[c] || train[c]) ? S_YELLOW : S_GREEN;
          S_GREEN:   if (train[c]) nxt[c] = S_YELLOW;
          S_YELLOW:  if (done[c]) nxt[c] = S_RED_OCC;
          S_RED_OCC: if (!train[c]) nxt[c] = S_RED_CLR;
          default:   nxt[c] = S_DIS;
        endcase
      end

      entry[c]  = (nxt[c] != state[c]);
      latch[c]  = (state[c] == S_DIS && nxt[c] == S_RED_CLR) ||
                  (state[c] != S_YELLOW && nxt[c] == S_YELLOW);
      served[c] = enable && state[c] == S_RED_OCC && !train[c];
      // tck saturates, so the timeout fires once per red-occupied visit
      tmo[c]    = enable && state[c] == S_RED_OCC && train[c] && tick[c] &&
                  tlim[c] != '0 && tck_inc[c] == {1'b0, tlim[c]};
      inc       = inc + 32'(served[c]);
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (!clrn) begin
        state[c] <= S_DIS;
        prof[c]  <= '0;
        pre[c]   <= '0;
        tck[c]   <= '0;
        bcnt[c]  <= '0;
        pend[c]  <= 1'b0;
      end else begin
        state[c] <= nxt[c];
        if (latch[c]) prof[c] <= prof_ram[psel[c*PW +: PW]];
        if (entry[c]) begin
          pre[c] <= '0;
          tck[c] <= '0;
        end else if (tick[c]) begin
          pre[c] <= '0;
          if (tck[c] != '1) tck[c] <= tck[c] + DUR_W'(1);
        end else begin
          pre[c] <= pre[c] + PRE_W'(1);
        end
        if (!enable || (entry[c] && nxt[c] == S_YELLOW)) pend[c] <= 1'b0;
        else if (state[c] == S_GMIN && train[c]) pend[c] <= 1'b1;
        // Blink phase is held at zero outside DIS-with-blink so it restarts lit.
        if (state[c] != S_DIS || !blink) bcnt[c] <= '0;
        else if (bcnt[c] == BLK_W'(2 * TICK_DIV - 1)) bcnt[c] <= '0;
        else bcnt[c] <= bcnt[c] + BLK_W'(1);
      end
    end
  end

  always_comb begin
    status = '0;
    for (int c = 0; c < N_CH; c++) begin
      red[c]    = (state[c] == S_RED_CLR) || (state[c] == S_RED_OCC);
      green[c]  = (state[c] == S_GMIN) || (state[c] == S_GREEN);
      yellow[c] = (state[c] == S_YELLOW) ||
                  (state[c] == S_DIS && blink && bcnt[c] < BLK_W'(TICK_DIV));
      status[3*c +: 3] = {red[c], yellow[c], green[c]};
      status[24+c]     = fault[c];
    end
  end

  always_comb begin
    case (ctl_addr)
      2'd0:    rd_mux = {30'd0, blink, enable};
      2'd1:    rd_mux = 32'(psel);
      2'd2:    rd_mux = cnt;
      default: rd_mux = status;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      enable     <= 1'b0;
      blink      <= 1'b0;
      psel       <= '0;
      cnt        <= '0;
      fault      <= '0;
      ctl_rddata <= '0;
    end else begin
      if (ctl_wr && ctl_addr == 2'd0) begin
        enable <= ctl_wrdata[0];
        blink  <= ctl_wrdata[1];
      end
      if (ctl_wr && ctl_addr == 2'd1) psel <= ctl_wrdata[N_CH*PW-1:0];
      if (ctl_wr && ctl_addr == 2'd2) cnt <= '0;
      else cnt <= cnt + inc;
      if (ctl_wr && ctl_addr == 2'd0 && ctl_wrdata[2]) fault <= tmo;
      else fault <= fault | tmo;
      if (ctl_rd) ctl_rddata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sem_multi_ctrl.sv
// tb/tb_sem_multi_ctrl.sv - self-checking bench for sem_multi_ctrl
// Register vector table followed by directed lamp-timing sequences.
module tb_sem_multi_ctrl;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        ctl_wr = 1'b0;
  logic        ctl_rd = 1'b0;
  logic [1:0]  ctl_addr = '0;
  logic [31:0] ctl_wrdata = '0;
  logic [31:0] ctl_rddata;
  logic        ram_wr = 1'b0;
  logic [1:0]  ram_addr = '0;
  logic [31:0] ram_wrdata = '0;
  logic [1:0]  train = '0;
  logic [1:0]  red, yellow, green;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] L_OFF = 3'b000, L_R = 3'b100, L_Y = 3'b010, L_G = 3'b001;

  sem_multi_ctrl #(.N_CH(2), .PROF_DEPTH(4), .DUR_W(8), .TICK_DIV(4)) dut (
    .clk(clk), .clrn(clrn), .ctl_wr(ctl_wr), .ctl_rd(ctl_rd), .ctl_addr(ctl_addr),
    .ctl_wrdata(ctl_wrdata), .ctl_rddata(ctl_rddata), .ram_wr(ram_wr),
    .ram_addr(ram_addr), .ram_wrdata(ram_wrdata), .train(train),
    .red(red), .yellow(yellow), .green(green)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [16];

  function automatic logic [2:0] lamp(input int c);
    return {red[c], yellow[c], green[c]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    ctl_wr = 1'b1; ctl_addr = a; ctl_wrdata = d;
    @(negedge clk);
    ctl_wr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    ctl_rd = 1'b1; ctl_addr = a;
    @(negedge clk);
    ctl_rd = 1'b0;
    d = ctl_rddata;
  endtask

  task automatic ram_write(input logic [1:0] a, input logic [31:0] d);
    ram_wr = 1'b1; ram_addr = a; ram_wrdata = d;
    @(negedge clk);
    ram_wr = 1'b0;
  endtask

  task automatic wait_lamp(input int c, input logic [2:0] val, input string name);
    int n = 0;
    while (lamp(c) != val && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(n < 200), 32'd1);
  endtask

  task automatic count_run(input int c, input logic [2:0] val, output int n);
    n = 0;
    while (lamp(c) == val && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] d;
    int n, g, y0, y1;

    vt[0]  = '{1'b0, 1'b1, 2'd0, 32'h0,        32'h0};
    vt[1]  = '{1'b0, 1'b1, 2'd1, 32'h0,        32'h0};
    vt[2]  = '{1'b0, 1'b1, 2'd2, 32'h0,        32'h0};
    vt[3]  = '{1'b0, 1'b1, 2'd3, 32'h0,        32'h0};
    vt[4]  = '{1'b1, 1'b0, 2'd1, 32'h5,        32'h0};
    vt[5]  = '{1'b0, 1'b1, 2'd1, 32'h0,        32'h5};
    vt[6]  = '{1'b1, 1'b1, 2'd1, 32'hA,        32'h5};
    vt[7]  = '{1'b0, 1'b1, 2'd1, 32'h0,        32'hA};
    vt[8]  = '{1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 32'h0};
    vt[9]  = '{1'b0, 1'b1, 2'd1, 32'h0,        32'hF};
    vt[10] = '{1'b1, 1'b0, 2'd0, 32'h6,        32'h0};
    vt[11] = '{1'b0, 1'b1, 2'd0, 32'h0,        32'h2};
    vt[12] = '{1'b1, 1'b0, 2'd0, 32'h0,        32'h0};
    vt[13] = '{1'b0, 1'b1, 2'd0, 32'h0,        32'h0};
    vt[14] = '{1'b1, 1'b0, 2'd1, 32'h0,        32'h0};
    vt[15] = '{1'b0, 1'b1, 2'd1, 32'h0,        32'h0};

    // Reset
    repeat (3) @(negedge clk);
    check("reset_lamps_ch0", 32'(lamp(0)), 32'(L_OFF));
    check("reset_lamps_ch1", 32'(lamp(1)), 32'(L_OFF));
    clrn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      ctl_wr = vt[i].wr; ctl_rd = vt[i].rd; ctl_addr = vt[i].addr; ctl_wrdata = vt[i].data;
      @(negedge clk);
      ctl_wr = 1'b0; ctl_rd = 1'b0;
      if (vt[i].rd) check($sformatf("reg_vec_%0d", i), ctl_rddata, vt[i].exp);
    end

    // Basic cycle on ch0 with profile 0
    ram_write(2'd0, 32'h00030205);
    wr(2'd0, 32'h1);
    wait_lamp(0, L_R, "basic_wait_red");
    count_run(0, L_R, n);
    check("basic_red_len", n, 12);
    g = 0;
    while (lamp(0) == L_G && g < 200) begin
      train[0] = (g == 2);
      g++;
      @(negedge clk);
    end
    train[0] = 1'b0;
    check("basic_green_len", g, 20);
    count_run(0, L_Y, n);
    check("basic_yellow_len", n, 8);
    count_run(0, L_R, n);
    check("basic_red_after_len", n, 13);
    check("basic_green_again", 32'(lamp(0)), 32'(L_G));
    check("basic_ch1_green", 32'(lamp(1)), 32'(L_G));
    rd(2'd2, d);
    check("basic_cnt", d, 32'd1);

    // Red-occupancy timeout on ch0 via profile 1
    ram_write(2'd1, 32'h02010301);
    wr(2'd1, 32'h1);
    train[0] = 1'b1;
    wait_lamp(0, L_R, "tmo_wait_red");
    repeat (7) @(negedge clk);
    rd(2'd3, d);
    check("tmo_status_before", d, 32'h0000000C);
    rd(2'd3, d);
    check("tmo_status_set", d, 32'h0100000C);
    repeat (60) @(negedge clk);
    check("tmo_still_red", 32'(lamp(0)), 32'(L_R));
    wr(2'd0, 32'h5);
    rd(2'd3, d);
    check("tmo_fault_cleared", d, 32'h0000000C);
    train[0] = 1'b0;
    repeat (20) @(negedge clk);
    rd(2'd2, d);
    check("tmo_cnt", d, 32'd2);
    check("tmo_ch0_green", 32'(lamp(0)), 32'(L_G));

    // Independent channels: ch0 Y=3, ch1 Y=1
    ram_write(2'd2, 32'h00010101);
    wr(2'd1, 32'h9);
    train = 2'b11;
    y0 = 0; y1 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (lamp(0) == L_R) break;
      if (lamp(0) == L_Y) y0++;
      if (lamp(1) == L_Y) y1++;
    end
    check("ind_ch0_yellow", y0, 12);
    check("ind_ch1_yellow", y1, 4);
    check("ind_ch1_red", 32'(lamp(1)), 32'(L_R));
    train = 2'b00;
    repeat (3) @(negedge clk);
    rd(2'd2, d);
    check("ind_cnt_plus2", d, 32'd4);

    // Disable with blink mid-yellow
    repeat (12) @(negedge clk);
    train[0] = 1'b1;
    wait_lamp(0, L_Y, "blink_wait_yellow");
    train[0] = 1'b0;
    wr(2'd0, 32'h3);
    wr(2'd0, 32'h2);
    check("dis_ch0_still_yellow", 32'(lamp(0)), 32'(L_Y));
    check("dis_ch1_still_green", 32'(lamp(1)), 32'(L_G));
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("blink_ch0_%0d", i), 32'(lamp(0)), (i % 8 < 4) ? 32'(L_Y) : 32'(L_OFF));
      check($sformatf("blink_ch1_%0d", i), 32'(lamp(1)), (i % 8 < 4) ? 32'(L_Y) : 32'(L_OFF));
    end
    wr(2'd0, 32'h0);
    check("off_ch0", 32'(lamp(0)), 32'(L_OFF));
    check("off_ch1", 32'(lamp(1)), 32'(L_OFF));

    // Zero durations: every interval one tick, no timeout
    ram_write(2'd3, 32'h00000000);
    wr(2'd1, 32'hF);
    wr(2'd0, 32'h1);
    wait_lamp(0, L_R, "zero_wait_red");
    count_run(0, L_R, n);
    check("zero_red_len", n, 4);
    train[0] = 1'b1;
    count_run(0, L_G, n);
    check("zero_green_len", n, 4);
    count_run(0, L_Y, n);
    check("zero_yellow_len", n, 4);
    repeat (20) @(negedge clk);
    check("zero_occ_red", 32'(lamp(0)), 32'(L_R));
    rd(2'd3, d);
    check("zero_no_fault", d, 32'h0000000C);
    train[0] = 1'b0; ctl_wr = 1'b1; ctl_addr = 2'd2; ctl_wrdata = 32'h0;
    @(negedge clk);
    ctl_wr = 1'b0;
    rd(2'd2, d);
    check("cnt_clear_wins", d, 32'd0);

    // RAM rewrite during GMIN only affects the next latch
    wait_lamp(0, L_G, "ram_wait_green");
    g = 0;
    while (lamp(0) == L_G && g < 200) begin
      ram_wr = (g == 0); ram_addr = 2'd3; ram_wrdata = 32'h00000203;
      if (g == 1) train[0] = 1'b1;
      g++;
      @(negedge clk);
    end
    ram_wr = 1'b0;
    train[0] = 1'b0;
    check("ram_green_unchanged", g, 4);
    count_run(0, L_Y, n);
    check("ram_yellow_new", n, 8);
    @(negedge clk);
    rd(2'd2, d);
    check("ram_cnt", d, 32'd1);

    // Reset mid-operation
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    check("mid_reset_ch0", 32'(lamp(0)), 32'(L_OFF));
    check("mid_reset_ch1", 32'(lamp(1)), 32'(L_OFF));
    rd(2'd3, d);
    check("mid_reset_status", d, 32'h0);
    rd(2'd2, d);
    check("mid_reset_cnt", d, 32'h0);
    rd(2'd1, d);
    check("mid_reset_psel", d, 32'h0);
    rd(2'd0, d);
    check("mid_reset_ctrl", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sem_multi_ctrl.md
Name: sem_multi_ctrl

Overview:
- Multi-channel level-crossing semaphore controller; next generation of the single-channel dec block.
- Runs N_CH independent channels, each with its own train input and red/yellow/green lamp outputs.
- Shares one register port and one timing-profile RAM of PROF_DEPTH entries; each channel selects its own profile.
- Adds min-green hold with pending-train latch, red-occupancy timeout fault, blink-when-disabled mode and a served-train counter.

Parameters:
- N_CH, 2, number of channels (1..8).
- PROF_DEPTH, 4, profile RAM entries (power of 2, >=2); PW = clog2(PROF_DEPTH).
- DUR_W, 8, width of one duration field; a RAM word is 4*DUR_W bits.
- TICK_DIV, 1000, clock cycles per timing tick (>=2).

Ports:
- clk  in  1  clock.
- clrn  in  1  synchronous active-low reset.
- ctl_wr  in  1  register write strobe.
- ctl_rd  in  1  register read strobe.
- ctl_addr  in  2  register offset.
- ctl_wrdata  in  32  register write data.
- ctl_rddata  out  32  register read data.
- ram_wr  in  1  profile RAM write strobe.
- ram_addr  in  PW  profile RAM index.
- ram_wrdata  in  4*DUR_W  profile word: [DUR_W-1:0]=G (min green), [2DUR_W-1:DUR_W]=Y, [3DUR_W-1:2DUR_W]=R (red clear), [4DUR_W-1:3DUR_W]=T (red timeout, 0 = off).
- train  in  N_CH  per-channel train-present, synchronous level.
- red, yellow, green  out  N_CH  per-channel lamps.

Behaviour:
- Clock is clk; reset clrn is synchronous and active-low.
- Reset: all registers 0, every channel in DIS, all lamps 0, ctl_rddata 0, counter 0, faults 0; RAM contents are not reset.
- Registers:
  - 0 CTRL: [0] enable, [1] blink; [2] write-1-clears all faults and reads 0.
  - 1 PSEL: channel c profile index at [c*PW +: PW].
  - 2 CNT: read returns served trains, all channels, 32-bit wrapping; any write clears it. A served-train increment in the same cycle as the clear gives 0.
  - 3 STATUS (RO): [3c+2:3c] = {red,yellow,green} of channel c; [24+c] = sticky fault c.
- Writes take effect next cycle.
- Reads: ctl_rddata loads on the edge where ctl_rd is sampled high and holds until the next read. ctl_wr and ctl_rd together on one address: the read returns the old value.
- RAM: a write is visible next cycle. A channel copies its whole profile word into local registers ("latch") only at entry to RED_CLR from DIS and at entry to YELLOW. RAM or PSEL changes never alter an interval already in progress.
- Per-channel timing: a local prescaler and tick counter reset on every state entry. An interval of D ticks lasts exactly max(D,1)*TICK_DIV cycles.
- Per-channel FSM; lamps are decoded from the registered state:
  - DIS: enable=1 -> RED_CLR (latch).
  - RED_CLR (red): train=1 -> RED_OCC; R elapsed -> GMIN.
  - GMIN (green): train=1 sets pend; G elapsed -> YELLOW if pend (or train) else GREEN.
  - GREEN (green): train=1 -> YELLOW.
  - YELLOW (yellow): latch on entry; pend cleared on entry; Y elapsed -> RED_OCC.
  - RED_OCC (red): train=0 -> RED_CLR and CNT+1; T!=0 and T ticks elapsed with train=1 -> set fault c, stay red.
- Same-cycle increments from several channels all add to CNT.
- enable=0 in any state: the next state is DIS, pend is cleared, and interval progress is lost. Disable has priority over all transitions.
- DIS lamps:
  - blink=0: all lamps off.
  - blink=1: yellow=1 for TICK_DIV cycles, then 0 for TICK_DIV cycles, repeating.
  - The blink phase restarts at yellow=1 whenever blink goes 0->1 or the channel enters DIS.
- Reset asserted mid-operation returns everything to the reset values on that edge.

Test Plan:
- Reset (TICK_DIV=4, N_CH=2, DUR_W=8): hold clrn=0 for 3 cycles -> lamps 000/000, STATUS=0, CNT=0.
- Basic cycle, ch0:
  - Stimulus: RAM[0]={T=0,R=3,Y=2,G=5}; CTRL=1; ch0 train pulse of 1 cycle issued 2 cycles after GMIN entry.
  - Required: red 12 cycles, then green held 20 cycles (pend), yellow 8 cycles.
  - RED_OCC exits after 1 cycle, then red 12 cycles, then green; CNT=1.
- Timeout:
  - Stimulus: RAM[1] with T=2; PSEL ch0=1; hold train 20 ticks.
  - Required: STATUS[24]=1 exactly 8 cycles after RED_OCC entry; lamp stays red.
  - CTRL write with bit2=1 -> STATUS[24]=0.
- Independence:
  - Stimulus: ch1 on profile 2 (G=1, Y=1, R=1); simultaneous trains on both channels.
  - Required: ch1 yellow 4 cycles, ch0 unaffected.
  - Both trains leave in the same cycle -> CNT increments by 2.
- Disable/blink: CTRL=3 mid-YELLOW, then CTRL=2 -> next cycle DIS; yellow 1,1,1,1,0,0,0,0 repeating; CTRL=0 -> lamps off.
- Zero durations and RAM write during operation:
  - Profile {0,0,0,0} -> every interval 4 cycles and no timeout.
  - Overwriting RAM during GMIN leaves the current G interval unchanged; the next YELLOW uses the new word.
